// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: control handshake, next-PC selects, instruction
// memory read channel and decoded instruction fields.
//   master : fetch-unit view (drives im_req/im_addr, IR fields, pc, status)
//   slave  : control-unit / memory view (drives requests, selects, read data)
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              fetch_req;
  logic              pc_update;
  logic              halt;
  logic              ret_sel;
  logic              jump;
  logic              branch_taken;
  logic [ADDR_W-1:0] ret_addr;
  logic [31:0]       im_rdata;
  logic              im_valid;
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              instr_valid;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fetch_err;

  modport master (
    input  fetch_req, pc_update, halt, ret_sel, jump, branch_taken, ret_addr,
           im_rdata, im_valid,
    output im_req, im_addr, instr_valid, opcode, rs, rt, rd, shamt, funct, imm,
           pc, halted, fetch_err
  );

  modport slave (
    output fetch_req, pc_update, halt, ret_sel, jump, branch_taken, ret_addr,
           im_rdata, im_valid,
    input  im_req, im_addr, instr_valid, opcode, rs, rt, rd, shamt, funct, imm,
           pc, halted, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory over a
// req/valid handshake, holds the word in an instruction register and
// computes the next PC on the control unit's pc_update pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - instr_fetch_unit_if.master (control, next-PC selects, memory
//          channel, decoded fields, pc, halted, fetch_err)
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT
// WAIT cycles without im_valid (sets fetch_err). Otherwise fetch_err is 0.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          TIMEOUT  = 15
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  // Elaboration-time parameter sanity checks
  if (RESET_PC[1:0] != 2'b00) begin : gBadResetPc
    $error("RESET_PC must be 4-byte aligned");
  end
  if (TIMEOUT == 0) begin : gBadTimeout
    $error("TIMEOUT must be at least 1");
  end
  if (ADDR_W <= 28) begin : gBadAddrW
    $error("ADDR_W must exceed 28 for the jump target format");
  end

  state_t            state, stateD;
  logic [ADDR_W-1:0] pc, pcD, nextPc, pc4, brOff;
  logic [31:0]       ir, irD;
  logic              imReq, imReqD;
  logic [ADDR_W-1:0] imAddr, imAddrD;
  logic              instrValid, instrValidD;
  logic              halted, haltedD;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cntD;
  logic             fetchErr, fetchErrD;
`endif

  // Next-PC select, highest priority first
  assign pc4   = pc + ADDR_W'(4);
  assign brOff = {{(ADDR_W-18){ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    nextPc = pc4;
    if (bus.halt)              nextPc = pc;
    else if (bus.ret_sel)      nextPc = {bus.ret_addr[ADDR_W-1:2], 2'b00};
    else if (bus.jump)         nextPc = {pc4[ADDR_W-1:28], ir[25:0], 2'b00};
    else if (bus.branch_taken) nextPc = pc4 + brOff;
  end

  // Next-state and registered-output logic
  always_comb begin
    stateD      = state;
    pcD         = pc;
    irD         = ir;
    imReqD      = 1'b0;
    imAddrD     = imAddr;
    instrValidD = instrValid;
    haltedD     = halted;
`ifdef FETCH_TIMEOUT_EN
    cntD        = cnt;
    fetchErrD   = fetchErr;
`endif
    case (state)
      IDLE: begin
        if (bus.fetch_req) begin
          stateD  = REQ;
          imReqD  = 1'b1;
          imAddrD = pc;
`ifdef FETCH_TIMEOUT_EN
          fetchErrD = 1'b0;
`endif
        end
      end
      REQ: begin
        // im_valid during the request cycle is not a response
        stateD = WAIT;
`ifdef FETCH_TIMEOUT_EN
        cntD = '0;
`endif
      end
      WAIT: begin
        if (bus.im_valid) begin
          irD         = bus.im_rdata;
          instrValidD = 1'b1;
          stateD      = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          fetchErrD = 1'b1;
          stateD    = IDLE;
        end else begin
          cntD = cnt + CNT_W'(1);
        end
`endif
      end
      HOLD: begin
        // pc_update outranks a coincident fetch_req, which is dropped
        if (bus.pc_update) begin
          pcD         = nextPc;
          instrValidD = 1'b0;
          if (bus.halt) begin
            stateD  = HALT;
            haltedD = 1'b1;
          end else begin
            stateD = IDLE;
          end
        end
      end
      HALT: begin
        stateD = HALT;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      imReq      <= 1'b0;
      imAddr     <= '0;
      instrValid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= stateD;
      pc         <= pcD;
      ir         <= irD;
      imReq      <= imReqD;
      imAddr     <= imAddrD;
      instrValid <= instrValidD;
      halted     <= haltedD;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // WAIT-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      fetchErr <= 1'b0;
    end else begin
      cnt      <= cntD;
      fetchErr <= fetchErrD;
    end
  end
  assign bus.fetch_err = fetchErr;
`else
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.im_req      = imReq;
  assign bus.im_addr     = imAddr;
  assign bus.instr_valid = instrValid;
  assign bus.pc          = pc;
  assign bus.halted      = halted;

  // Decoded fields are plain slices of the instruction register
  assign bus.opcode = ir[31:26];
  assign bus.rs     = ir[25:21];
  assign bus.rt     = ir[20:16];
  assign bus.rd     = ir[15:11];
  assign bus.shamt  = ir[10:6];
  assign bus.funct  = ir[5:0];
  assign bus.imm    = ir[15:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multi-cycle control unit.
- Owns the program counter and issues a read to instruction memory using a req/valid handshake.
- Latches the returned word into an instruction register and presents the decoded fields (opcode, rs, rt, rd, shamt, funct, imm) to the control unit.
- On the control unit's PC-update pulse, computes the next PC: sequential, jump, branch, return or halt.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- TIMEOUT, 15, max cycles spent in WAIT before fetch_err; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_req  in  1  start fetch at current PC; honoured only in IDLE.
- pc_update  in  1  one-cycle pulse from control; honoured only in HOLD.
- halt  in  1  next-PC select: freeze.
- ret_sel  in  1  next-PC select: return address.
- jump  in  1  next-PC select: jump.
- branch_taken  in  1  next-PC select: branch.
- ret_addr  in  ADDR_W  return target.
- im_rdata  in  32  instruction memory data.
- im_valid  in  1  im_rdata valid this cycle.
- im_req  out  1  memory read request, one-cycle pulse.
- im_addr  out  ADDR_W  read address.
- instr_valid  out  1  IR holds a fresh instruction.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- shamt  out  5  ir[10:6].
- funct  out  6  ir[5:0].
- imm  out  16  ir[15:0].
- pc  out  ADDR_W  current PC.
- halted  out  1  in HALT state.
- fetch_err  out  1  timeout flag, sticky until the next fetch_req.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, ir=0.
  - im_req=0, im_addr=0, instr_valid=0, halted=0, fetch_err=0.
  - Timeout counter=0.
  - An im_valid that arrives after reset is ignored.
- Decoded field outputs are combinational slices of ir. They stay stable between fetches.
- States IDLE, REQ, WAIT, HOLD, HALT; all transitions occur on the rising clk edge.
- IDLE:
  - fetch_req=1 → REQ, with fetch_err cleared.
  - pc_update and im_valid are ignored.
- REQ:
  - im_req=1 and im_addr=pc for exactly one cycle, then → WAIT.
  - im_valid seen in the same cycle as im_req is ignored; minimum memory latency is 1 cycle.
- WAIT:
  - On im_valid=1: ir←im_rdata, → HOLD.
  - instr_valid=1 from the first HOLD cycle. Total fetch latency from fetch_req is 3 cycles with a 1-cycle memory.
- HOLD:
  - instr_valid held at 1; fetch_req is ignored.
  - On pc_update=1: pc←next_pc, instr_valid←0, → IDLE, or → HALT if halt=1.
- next_pc priority, highest first:
  - halt: pc unchanged.
  - ret_sel: {ret_addr[ADDR_W-1:2],2'b00}.
  - jump: {pc4[ADDR_W-1:28], ir[25:0], 2'b00}.
  - branch_taken: pc4 + (sign_ext(imm)<<2).
  - otherwise: pc4.
- pc4 = pc+4, wrapping mod 2^ADDR_W. Branch arithmetic also wraps, with no overflow flag.
- HALT:
  - halted=1, pc frozen; all inputs ignored until rst.
  - instr_valid=0, im_req=0.
- Simultaneous fetch_req and pc_update in HOLD: pc_update wins and fetch_req is dropped. Control must re-issue fetch_req in IDLE.
- pc[1:0] is always 0.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without im_valid.
  - When it reaches TIMEOUT: fetch_err←1, → IDLE, ir and pc unchanged.
  - A late im_valid is ignored.
- Undefined:
  - WAIT waits indefinitely.
  - fetch_err is tied to 0 and no counter logic exists.

Test Plan:
- Reset then fetch:
  - Stimulus: rst, fetch_req=1 for 1 cycle, memory returns 0x00A62020 1 cycle after im_req.
  - Response: im_req pulses with im_addr=0; instr_valid=1 3 cycles after fetch_req.
  - Fields: opcode=0, rs=5, rt=6, rd=4, shamt=0, funct=0x20.
- Sequential/branch:
  - Stimulus: pc=0x10 in HOLD, pc_update with branch_taken=1, imm=0xFFFE.
  - Response: pc=0x0C.
  - Same setup with no selects: pc=0x14.
- Jump/ret priority:
  - Stimulus: pc=0x100, ir[25:0]=0x40, jump=1 and ret_sel=1, ret_addr=0x207.
  - Response: pc=0x204 (ret wins, alignment forced).
  - jump alone: pc=0x100.
- Wrap and halt:
  - Stimulus: pc=0xFFFFFFFC, pc_update.
  - Response: pc=0.
  - Then pc_update with halt=1: halted=1, later fetch_req ignored, pc unchanged, im_req stays 0.
- Reset mid-fetch:
  - Stimulus: assert rst in WAIT, then im_valid arrives.
  - Response: outputs are at reset values immediately; ir=0, instr_valid=0.
- FETCH_TIMEOUT_EN:
  - Stimulus: no im_valid for 15 WAIT cycles.
  - Response: fetch_err=1, state IDLE.
  - Next fetch_req clears fetch_err and re-fetches the same pc.
